// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/synchroniser block: FSM state encoding
// and the default parameter values used by debounce_sync.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } db_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_GLITCH_W        = 8;

  // Level that d_clean presents while the FSM sits in the given state.
  function automatic logic state_level(input db_state_e st);
    logic lvl;
    case (st)
      STABLE_HI: lvl = 1'b1;
      QUAL_LO:   lvl = 1'b1;
      STABLE_LO: lvl = 1'b0;
      QUAL_HI:   lvl = 1'b0;
      default:   lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Generic multi-flop synchroniser for an asynchronous single-bit level.
// Shared with other blocks; the last stage is the only safe output.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises a noisy asynchronous level, qualifies each level change over
// DEBOUNCE_CYCLES stable cycles, and reports edges and aborted changes.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  output logic                d_clean,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  logic                sync_q;
  db_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                d_clean_q, d_clean_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q, busy_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (raw_in),
    .q  (sync_q)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter qualification on a level change, finish or abort it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STABLE_LO: begin
        if (sync_q) state_d = QUAL_HI;
        else        state_d = STABLE_LO;
      end
      QUAL_HI: begin
        if (!sync_q)              state_d = STABLE_LO;
        else if (cnt_q == CNT_LAST) state_d = STABLE_HI;
        else                      state_d = QUAL_HI;
      end
      STABLE_HI: begin
        if (!sync_q) state_d = QUAL_LO;
        else         state_d = STABLE_HI;
      end
      QUAL_LO: begin
        if (sync_q)               state_d = STABLE_HI;
        else if (cnt_q == CNT_LAST) state_d = STABLE_LO;
        else                      state_d = QUAL_LO;
      end
      default: state_d = STABLE_LO;
    endcase
  end

  // Outputs and datapath next values, all derived from the current/next state
  // so every port comes straight from a flop.
  always_comb begin
    cnt_d     = '0;
    glitch_d  = glitch_q;
    d_clean_d = state_level(state_d);
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    busy_d    = 1'b0;
    case (state_q)
      STABLE_LO, STABLE_HI: begin
        if (state_d == QUAL_HI || state_d == QUAL_LO) cnt_d = CNT_ONE;
        else                                          cnt_d = '0;
      end
      QUAL_HI, QUAL_LO: begin
        if (state_d == state_q) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (state_level(state_d) == state_level(state_q)) begin
          // Candidate level was lost before qualifying: count the glitch.
          cnt_d = '0;
          if (glitch_q != GLITCH_MAX) glitch_d = glitch_q + GLITCH_ONE;
          else                        glitch_d = glitch_q;
        end else begin
          cnt_d = '0;
        end
      end
      default: cnt_d = '0;
    endcase
    if (state_q == QUAL_HI && state_d == STABLE_HI) rise_d = 1'b1;
    else                                            rise_d = 1'b0;
    if (state_q == QUAL_LO && state_d == STABLE_LO) fall_d = 1'b1;
    else                                            fall_d = 1'b0;
    if (state_d == QUAL_HI || state_d == QUAL_LO) busy_d = 1'b1;
    else                                          busy_d = 1'b0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      glitch_q  <= '0;
      d_clean_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      glitch_q  <= glitch_d;
      d_clean_q <= d_clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
    end
  end

  assign d_clean    = d_clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length reference model predicts
// d_clean, busy, glitch_cnt and edge events; a negedge monitor compares.
module tb_debounce_sync;

  localparam int SS = 2;
  localparam int DC = 8;
  localparam int GW = 8;

  logic          clk;
  logic          rst;
  logic          raw_in;
  logic          d_clean;
  logic          rise_pulse;
  logic          fall_pulse;
  logic          busy;
  logic [GW-1:0] glitch_cnt;
  logic          dff_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       level;
    bit [7:0] glitch;
  } edge_ev_t;
  edge_ev_t sbq[$];

  // Reference model state
  bit       hist[SS];
  bit       exp_clean;
  bit       exp_q;
  int       run_len;
  bit [7:0] exp_glitch;
  int       exp_rises, exp_falls, rise_seen, fall_seen;

  debounce_sync #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .GLITCH_W(GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .d_clean   (d_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream D flip-flop fed by d_clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dff_q <= 1'b0;
    else     dff_q <= d_clean;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    exp_clean  = 1'b0;
    exp_q      = 1'b0;
    run_len    = 0;
    exp_glitch = 8'd0;
    sbq.delete();
  endtask

  // Model one rising edge: the logic sees raw_in from SS edges ago; a level
  // differing from d_clean for DC consecutive edges is accepted, a shorter
  // run that breaks is a glitch.
  task automatic model_edge(input bit r);
    bit       s;
    edge_ev_t ev;
    s = hist[SS-1];
    for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = r;
    exp_q = exp_clean;
    if (s != exp_clean) begin
      run_len++;
      if (run_len == DC) begin
        exp_clean = s;
        run_len   = 0;
        ev.level  = s;
        ev.glitch = exp_glitch;
        sbq.push_back(ev);
        if (s) exp_rises++;
        else   exp_falls++;
      end
    end else if (run_len != 0) begin
      run_len = 0;
      if (exp_glitch != 8'd255) exp_glitch++;
    end
  endtask

  // One clock cycle starting and ending at a falling edge.
  task automatic cycle(input bit v);
    raw_in = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
  endtask

  // Sub-period pulse entirely between two rising edges.
  task automatic short_pulse();
    raw_in = 1'b1;
    #2;
    raw_in = 1'b0;
    @(posedge clk);
    model_edge(1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_d_clean", d_clean, 0);
    chk("rst_rise", rise_pulse, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_glitch", glitch_cnt, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Hold raw_in at v until d_clean reaches v (bounded); returns edge count and busy cycles.
  task automatic measure(input bit v, output int n, output int bsy);
    n = 0;
    bsy = 0;
    do begin
      cycle(v);
      n++;
      if (busy) bsy++;
    end while (d_clean != v && n < 30);
  endtask

  // Monitor: compare every cycle against the model and pop edge events.
  always @(negedge clk) begin
    edge_ev_t ev;
    if (!rst) begin
      chk("d_clean", d_clean, exp_clean);
      chk("busy", busy, (run_len != 0) ? 1 : 0);
      chk("glitch_cnt", glitch_cnt, exp_glitch);
      chk("dff_q", dff_q, exp_q);
      chk("pulse_exclusive", rise_pulse & fall_pulse, 0);
      if (rise_pulse || fall_pulse) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {rise_pulse, fall_pulse}, 0);
        end else begin
          ev = sbq.pop_front();
          chk("pulse_rise", rise_pulse, ev.level);
          chk("pulse_fall", fall_pulse, !ev.level);
          chk("pulse_glitch", glitch_cnt, ev.glitch);
          if (rise_pulse) rise_seen++;
          if (fall_pulse) fall_seen++;
        end
      end else if (sbq.size() != 0) begin
        ev = sbq.pop_front();
        chk("missing_pulse", {rise_pulse, fall_pulse}, ev.level ? 2 : 1);
      end
    end
  end

  initial begin
    int n, bsy, r0, seg, lvl;
    exp_rises = 0; exp_falls = 0; rise_seen = 0; fall_seen = 0;
    model_reset();
    rst    = 1'b1;
    raw_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Quiet input
    repeat (50) cycle(1'b0);
    chk("quiet_d_clean", d_clean, 0);
    chk("quiet_glitch", glitch_cnt, 0);
    chk("quiet_busy", busy, 0);

    // Clean rising step: latency and busy length
    r0 = rise_seen;
    measure(1'b1, n, bsy);
    chk("rise_latency", n, SS + DC);
    chk("rise_busy_cycles", bsy, DC - 1);
    cycle(1'b1);
    chk("rise_pulse_count", rise_seen - r0, 1);
    repeat (4) cycle(1'b1);

    // Clean falling step
    r0 = fall_seen;
    measure(1'b0, n, bsy);
    chk("fall_latency", n, SS + DC);
    cycle(1'b0);
    chk("fall_pulse_count", fall_seen - r0, 1);
    repeat (4) cycle(1'b0);

    // Short highs abort and saturate the glitch counter
    for (int k = 0; k < 300; k++) begin
      repeat (5) cycle(1'b1);
      repeat (3) cycle(1'b0);
      if (k == 0) chk("glitch_first", glitch_cnt, 1);
    end
    chk("glitch_saturated", glitch_cnt, 255);
    chk("glitch_d_clean", d_clean, 0);

    // Toggling every 3 cycles, then steady high
    do_reset();
    r0 = rise_seen;
    for (int k = 0; k < 20; k++) repeat (3) cycle(k[0] ? 1'b0 : 1'b1);
    chk("toggle_no_rise", d_clean, 0);
    repeat (15) cycle(1'b1);
    chk("toggle_single_rise", rise_seen - r0, 1);
    chk("toggle_glitch_nonzero", (glitch_cnt > 0) ? 1 : 0, 1);
    chk("toggle_d_clean", d_clean, 1);

    // Falling to low, then sub-period pulses must not qualify
    repeat (15) cycle(1'b0);
    r0 = rise_seen;
    repeat (20) short_pulse();
    chk("short_no_rise", rise_seen - r0, 0);
    chk("short_d_clean", d_clean, 0);

    // Reset in the middle of a qualification, raw_in left high
    repeat (12) cycle(1'b1);
    repeat (12) cycle(1'b0);
    repeat (SS + 6) cycle(1'b1);
    chk("midqual_busy", busy, 1);
    r0 = rise_seen;
    do_reset();
    chk("midqual_no_pulse", rise_seen - r0, 0);
    measure(1'b1, n, bsy);
    chk("post_reset_latency", n, SS + DC);
    cycle(1'b1);
    chk("post_reset_rise", rise_seen - r0, 1);

    // Randomised segments
    for (int k = 0; k < 200; k++) begin
      seg = $urandom_range(14, 1);
      lvl = $urandom_range(1, 0);
      repeat (seg) cycle(lvl[0]);
    end
    repeat (20) cycle(1'b0);

    chk("total_rises", rise_seen, exp_rises);
    chk("total_falls", fall_seen, exp_falls);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops (legal 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8, consecutive stable cycles required to accept a level change (legal 2..65535).
REQ-003 Parameter GLITCH_W, default 8, width of the glitch counter.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port raw_in, input, 1, asynchronous noisy level (button, external line).
REQ-007 Port d_clean, output, 1, debounced level; drives the d input of the downstream D flip-flop stage.
REQ-008 Port rise_pulse, output, 1, one-cycle pulse when d_clean goes 0->1.
REQ-009 Port fall_pulse, output, 1, one-cycle pulse when d_clean goes 1->0.
REQ-010 Port busy, output, 1, high while a candidate transition is being qualified.
REQ-011 Port glitch_cnt, output, GLITCH_W, saturating count of aborted transitions.

Function
REQ-012 raw_in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync_q) feeds the logic.
REQ-013 FSM states SHALL be STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-014 STABLE_LO -> QUAL_HI when sync_q=1, counter loaded to 1; STABLE_HI -> QUAL_LO when sync_q=0, counter loaded to 1.
REQ-015 In QUAL_x, each edge with sync_q at the candidate level SHALL increment the counter; on the edge where the count would reach DEBOUNCE_CYCLES, the FSM SHALL enter the opposite STABLE state and d_clean SHALL toggle.
REQ-016 In QUAL_x, sync_q returning to the d_clean level SHALL abort: counter cleared, FSM back to the originating STABLE state, glitch_cnt incremented.
REQ-017 glitch_cnt SHALL saturate at all-ones and never wrap.
REQ-018 rise_pulse/fall_pulse SHALL be registered, high exactly for the cycle following the d_clean toggle edge, never both high together.
REQ-019 busy SHALL be high exactly when FSM is QUAL_HI or QUAL_LO.
REQ-020 Latency from a clean raw_in step to the d_clean change SHALL be SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
REQ-021 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL never exceed DEBOUNCE_CYCLES.
REQ-022 A raw_in pulse shorter than one clock period MAY be missed entirely; it SHALL NOT produce a d_clean change.

Reset
REQ-023 rst high SHALL asynchronously force: sync chain 0, FSM STABLE_LO, counter 0, d_clean 0, rise_pulse 0, fall_pulse 0, busy 0, glitch_cnt 0.
REQ-024 Reset asserted mid-qualification SHALL discard the candidate with no pulse and no glitch_cnt increment.
REQ-025 After rst deassertion with raw_in=1, the block SHALL qualify normally and raise d_clean after the REQ-020 latency, with one rise_pulse.

Structure
REQ-026 Shared package debounce_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-027 The synchroniser SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, rst, d, q), reused elsewhere.
REQ-028 The FSM, counter and pulse logic SHALL live in debounce_sync; there SHALL be no other sub-modules.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=8)
REQ-029 Reset, raw_in=0 held 50 cycles -> d_clean=0, no pulses, glitch_cnt=0, busy=0.
REQ-030 raw_in 0->1 held -> d_clean=1 exactly 10 edges later, one rise_pulse on the following cycle, busy high 7 cycles.
REQ-031 raw_in high 5 cycles then low (d_clean=0) -> no d_clean change, glitch_cnt=1; repeat 300 times -> glitch_cnt=255 (saturated).
REQ-032 raw_in toggling every 3 cycles for 60 cycles then steady 1 -> d_clean rises once, single rise_pulse, glitch_cnt>0.
REQ-033 d_clean=1, raw_in->0 -> d_clean=0 after 10 edges with one fall_pulse; rst asserted at cycle 6 of a new qualification -> all outputs 0 immediately, no pulse.
REQ-034 The bench SHALL connect d_clean to the D flip-flop's d input and check q follows d_clean one cycle later.
